// File: rtl/twin_reg_pkg.sv
// Shared types and constants for twin-register blocks.
package twin_reg_pkg;

    localparam int unsigned DEF_DW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam logic REQ_A   = 1'b0;
    localparam logic REQ_B   = 1'b1;
    localparam logic SLOT_Q1 = 1'b0;
    localparam logic SLOT_Q2 = 1'b1;

endpackage

// File: rtl/twin_reg_arb_rr.sv
// rr_arb2: two-way round-robin pointer and grant generation.
// Grants are combinational from state/ptr/valids; ptr moves to the loser on advance.
module rr_arb2
    import twin_reg_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   a_valid,
    input  logic   b_valid,
    input  state_t state,
    input  logic   advance,
    output logic   grant_a,
    output logic   grant_b,
    output logic   ptr
);

    // Owner side is granted unconditionally; in IDLE the pointer breaks ties.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        case (state)
            OWN_A: grant_a = 1'b1;
            OWN_B: grant_b = 1'b1;
            default: begin
                if (a_valid && b_valid) begin
                    grant_a = (ptr == REQ_A);
                    grant_b = (ptr == REQ_B);
                end else begin
                    grant_a = a_valid;
                    grant_b = b_valid;
                end
            end
        endcase
    end

    // Priority passes to the requester that was not just served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= REQ_A;
        end else if (advance) begin
            ptr <= grant_b ? REQ_A : REQ_B;
        end
    end

endmodule

// File: rtl/twin_reg_arb.sv
// twin_reg_arb: round-robin arbiter owning a twin register pair q1/q2, with locked bursts.
// Optional feature macro: TWIN_REG_ARB_PARITY_EN (registered even parity on q1_par/q2_par).
module twin_reg_arb
    import twin_reg_pkg::*;
#(
    parameter int unsigned DW        = DEF_DW,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_valid,
    input  logic          a_slot,
    input  logic [DW-1:0] a_data,
    input  logic          a_lock,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic          b_slot,
    input  logic [DW-1:0] b_data,
    input  logic          b_lock,
    output logic          b_ready,
    output logic [DW-1:0] q1,
    output logic [DW-1:0] q2,
    output logic          q1_src,
    output logic          q2_src,
    output logic          q1_par,
    output logic          q2_par
);

    localparam int unsigned CW = $clog2(BURST_MAX + 1);

    state_t        state;
    logic [CW-1:0] beat_cnt;
    logic          grant_a;
    logic          grant_b;
    logic          ptr;
    logic          advance;
    logic          acc;
    logic          owner_b;
    logic          w_slot;
    logic          w_lock;
    logic [DW-1:0] w_data;
    logic          enter_own;
    logic          leave_own;
    logic          cnt_last;

    rr_arb2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .b_valid (b_valid),
        .state   (state),
        .advance (advance),
        .grant_a (grant_a),
        .grant_b (grant_b),
        .ptr     (ptr)
    );

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    // Beat selection and FSM transition decisions.
    always_comb begin
        owner_b   = grant_b;
        acc       = (a_valid & grant_a) | (b_valid & grant_b);
        w_slot    = owner_b ? b_slot : a_slot;
        w_data    = owner_b ? b_data : a_data;
        w_lock    = owner_b ? b_lock : a_lock;
        cnt_last  = (beat_cnt == CW'(BURST_MAX - 1));
        enter_own = 1'b0;
        leave_own = 1'b0;
        advance   = 1'b0;
        if (state == IDLE) begin
            if (acc) begin
                if (w_lock && (BURST_MAX > 1)) begin
                    enter_own = 1'b1;
                end else begin
                    advance = 1'b1;
                end
            end
        end else begin
            if (acc) begin
                leave_own = !w_lock || cnt_last;
            end else begin
                leave_own = !w_lock;
            end
            advance = leave_own;
        end
    end

    // Ownership FSM and burst beat counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            beat_cnt <= '0;
        end else if (enter_own) begin
            state    <= owner_b ? OWN_B : OWN_A;
            beat_cnt <= CW'(1);
        end else if (leave_own) begin
            state    <= IDLE;
            beat_cnt <= '0;
        end else if ((state != IDLE) && acc) begin
            beat_cnt <= beat_cnt + CW'(1);
        end
    end

    // Accepted beat lands in its slot, tagged with the writing requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q1     <= '0;
            q2     <= '0;
            q1_src <= REQ_A;
            q2_src <= REQ_A;
        end else if (acc) begin
            if (w_slot == SLOT_Q1) begin
                q1     <= w_data;
                q1_src <= owner_b;
            end else begin
                q2     <= w_data;
                q2_src <= owner_b;
            end
        end
    end

`ifdef TWIN_REG_ARB_PARITY_EN
    // Even parity tracks each slot, updated with the same write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q1_par <= 1'b0;
            q2_par <= 1'b0;
        end else if (acc) begin
            if (w_slot == SLOT_Q1) begin
                q1_par <= ^w_data;
            end else begin
                q2_par <= ^w_data;
            end
        end
    end
`else
    assign q1_par = 1'b0;
    assign q2_par = 1'b0;
`endif

endmodule
